// File: rtl/fp_wb_arbiter_pkg.sv
// ============================================================================
// Module   : fp_wb_arbiter_pkg
// Brief    : Shared FP writeback payload types and helpers for the arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fp_wb_arbiter_pkg;

    typedef logic [63:0] fp_t;
    typedef logic [4:0]  id_t;
    typedef logic [2:0]  grs_t;
    typedef logic [6:0]  fp_shift_amt_t;
    typedef logic [4:0]  fflags_t;
    typedef logic [2:0]  rm_t;

    // Intermediate-writeback fields minus the done/ack handshake.
    typedef struct packed {
        fp_t           rd;
        id_t           id;
        logic          hidden;
        grs_t          grs;
        fp_shift_amt_t clz;
        logic          right_shift;
        fp_shift_amt_t right_shift_amt;
        logic          subnormal;
        logic          ignore_max_expo;
        logic          d2s;
        logic          expo_overflow;
        logic          carry;
        logic          safe;
        fflags_t       fflags;
        rm_t           rm;
    } fp_wb_payload_t;

    localparam int unsigned c_payload_w = $bits(fp_wb_payload_t);

    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fp_rr_priority_pick.sv
// ============================================================================
// Module   : fp_rr_priority_pick
// Brief    : Combinational circular first-one picker starting at rr_ptr.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fp_rr_priority_pick #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] rr_ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx
);

    localparam int unsigned    c_iw = $clog2(N);
    localparam logic [c_iw:0]  c_n  = (c_iw + 1)'(N);

    logic [c_iw:0] w_sum;
    logic          w_found;

    // rr_ptr < N, so one conditional subtract keeps the index in range.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        w_sum     = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, rr_ptr} + (c_iw + 1)'(k);
            if (w_sum >= c_n) begin
                w_sum = w_sum - c_n;
            end
            if (!w_found && req[w_sum[c_iw-1:0]]) begin
                w_found                = 1'b1;
                grant[w_sum[c_iw-1:0]] = 1'b1;
                grant_idx              = w_sum[c_iw-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fp_wb_arbiter.sv
// ============================================================================
// Module   : fp_wb_arbiter
// Brief    : Round-robin merge of FP unit writebacks into a small output FIFO.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fp_wb_arbiter
    import fp_wb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_UNITS = 4,
    parameter int unsigned DEPTH     = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic           [NUM_UNITS-1:0]       unit_done,
    input  fp_wb_payload_t [NUM_UNITS-1:0]       unit_payload,
    output logic           [NUM_UNITS-1:0]       unit_ack,
    output logic                                 out_valid,
    output fp_wb_payload_t                       out_payload,
    output logic           [$clog2(NUM_UNITS)-1:0] out_unit,
    input  logic                                 out_ready
);

    localparam int unsigned      c_uw        = $clog2(NUM_UNITS);
    localparam int unsigned      c_aw        = $clog2(DEPTH);
    localparam logic [c_aw:0]    c_depth_cnt = (c_aw + 1)'(DEPTH);
    localparam logic [c_aw-1:0]  c_ptr_one   = c_aw'(1);
    localparam logic [c_aw:0]    c_cnt_one   = (c_aw + 1)'(1);

    typedef struct packed {
        fp_wb_payload_t  payload;
        logic [c_uw-1:0] unit;
    } buf_ent_t;

    buf_ent_t         r_buf [DEPTH];
    logic [c_aw:0]    r_count;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_uw-1:0]  r_rr_ptr;

    logic                 w_space;
    logic [NUM_UNITS-1:0] w_req;
    logic [NUM_UNITS-1:0] w_grant;
    logic [c_uw-1:0]      w_grant_idx;
    logic                 w_push;
    logic                 w_pop;

    // Space comes from the registered count only, so ack never sees out_ready.
    // Reset gates ack/valid so nothing is handed off during a reset cycle.
    assign w_space = rst && (r_count != c_depth_cnt);
    assign w_req   = w_space ? unit_done : '0;

    fp_rr_priority_pick #(
        .N (NUM_UNITS)
    ) u_pick (
        .req       (w_req),
        .rr_ptr    (r_rr_ptr),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    assign unit_ack    = w_grant;
    assign w_push      = |w_grant;
    assign out_valid   = rst && (r_count != '0);
    assign w_pop       = out_valid && out_ready;
    assign out_payload = r_buf[r_rd_ptr].payload;
    assign out_unit    = r_buf[r_rd_ptr].unit;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf[r_wr_ptr] <= '{payload: unit_payload[w_grant_idx], unit: w_grant_idx};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_rr_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
                r_rr_ptr <= c_uw'(wrap_inc(32'(w_grant_idx), NUM_UNITS));
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

`ifndef SYNTHESIS
    a_ack_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(unit_ack));
    a_ack_done:   assert property (@(posedge clk) disable iff (!rst) (unit_ack & ~unit_done) == '0);
    a_no_ovf:     assert property (@(posedge clk) disable iff (!rst) !(w_push && (r_count == c_depth_cnt)));
`endif

endmodule

`default_nettype wire

// File: tb/tb_fp_wb_arbiter.sv
// ============================================================================
// Module   : tb_fp_wb_arbiter
// Brief    : Directed + random bench for fp_wb_arbiter against a queue model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fp_wb_arbiter;
    import fp_wb_arbiter_pkg::*;

    localparam int NU    = 4;
    localparam int DEPTH = 2;

    logic                        clk = 1'b0;
    logic                        rst;
    logic           [NU-1:0]     unit_done;
    fp_wb_payload_t [NU-1:0]     unit_payload;
    logic           [NU-1:0]     unit_ack;
    logic                        out_valid;
    fp_wb_payload_t              out_payload;
    logic           [1:0]        out_unit;
    logic                        out_ready;

    always #5 clk = ~clk;

    fp_wb_arbiter #(
        .NUM_UNITS (NU),
        .DEPTH     (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .unit_done    (unit_done),
        .unit_payload (unit_payload),
        .unit_ack     (unit_ack),
        .out_valid    (out_valid),
        .out_payload  (out_payload),
        .out_unit     (out_unit),
        .out_ready    (out_ready)
    );

    typedef struct packed {
        fp_wb_payload_t p;
        logic [1:0]     u;
    } ent_t;

    ent_t            q[$];
    logic [NU-1:0]   obs_acks[$];
    int              rr;
    int              errors = 0;
    int              checks = 0;
    int              obs_pops;
    logic [NU-1:0]   auto_rq;
    logic [4:0]      next_id;
    logic [NU-1:0]   last_ack;
    logic            last_valid;
    logic [1:0]      last_unit;
    fp_wb_payload_t  last_pay;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic fp_wb_payload_t mkpay(input logic [4:0] id);
        logic [127:0]   r;
        fp_wb_payload_t p;
        r    = {$urandom, $urandom, $urandom, $urandom};
        p    = r[c_payload_w-1:0];
        p.id = id;
        return p;
    endfunction

    task automatic raise(input int u);
        if (!unit_done[u]) begin
            unit_done[u]    = 1'b1;
            unit_payload[u] = mkpay(next_id);
            next_id++;
        end
    endtask

    // One clock: predict from the queue model, compare, then advance the model.
    task automatic cycle();
        logic [NU-1:0] exp_ack;
        logic          exp_valid;
        int            g;
        int            idx;
        exp_ack = '0;
        g       = -1;
        if (rst && q.size() < DEPTH) begin
            for (int k = 0; k < NU; k++) begin
                idx = (rr + k) % NU;
                if (unit_done[idx]) begin
                    g = idx;
                    break;
                end
            end
        end
        if (g >= 0) exp_ack[g] = 1'b1;
        exp_valid = rst && (q.size() > 0);
        #1;
        last_ack   = unit_ack;
        last_valid = out_valid;
        last_unit  = out_unit;
        last_pay   = out_payload;
        obs_acks.push_back(unit_ack);
        if (out_valid && out_ready) obs_pops++;
        chk("ack", unit_ack, exp_ack);
        chk("out_valid", out_valid, exp_valid);
        if (exp_valid) begin
            chk("out_payload", out_payload, q[0].p);
            chk("out_unit", out_unit, q[0].u);
        end
        @(posedge clk);
        #1;
        if (!rst) begin
            q.delete();
            rr = 0;
        end else begin
            if (exp_valid && out_ready) void'(q.pop_front());
            if (g >= 0) begin
                q.push_back('{p: unit_payload[g], u: 2'(g)});
                rr = (g + 1) % NU;
                if (auto_rq[g]) begin
                    unit_payload[g] = mkpay(next_id);
                    next_id++;
                end else begin
                    unit_done[g] = 1'b0;
                end
            end
        end
    endtask

    task automatic drain();
        int n;
        auto_rq   = '0;
        out_ready = 1'b1;
        n = 0;
        while ((unit_done != '0 || q.size() != 0) && n < 40) begin
            cycle();
            n++;
        end
        chk("drain_done", (unit_done == '0 && q.size() == 0), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int sent;
        rst          = 1'b0;
        unit_done    = '0;
        unit_payload = '0;
        out_ready    = 1'b0;
        auto_rq      = '0;
        next_id      = 5'd0;
        rr           = 0;
        obs_pops     = 0;

        cycle();
        cycle();
        chk("reset_ack", last_ack, 4'b0000);
        chk("reset_valid", last_valid, 1'b0);
        rst = 1'b1;

        // Single request from unit 1 with id 5.
        unit_done[1]    = 1'b1;
        unit_payload[1] = mkpay(5'd5);
        cycle();
        chk("single_ack", last_ack, 4'b0010);
        raise(0);
        raise(2);
        out_ready = 1'b1;
        cycle();
        chk("single_valid", last_valid, 1'b1);
        chk("single_unit", last_unit, 2'd1);
        chk("single_id", last_pay.id, 5'd5);
        chk("rr_after_unit1", last_ack, 4'b0100);
        drain();

        // Round-robin with all four units requesting continuously.
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        auto_rq = 4'b1111;
        for (int u = 0; u < NU; u++) raise(u);
        obs_acks.delete();
        for (int c = 0; c < 5; c++) cycle();
        chk("rr_seq0", obs_acks[0], 4'b0001);
        chk("rr_seq1", obs_acks[1], 4'b0010);
        chk("rr_seq2", obs_acks[2], 4'b0100);
        chk("rr_seq3", obs_acks[3], 4'b1000);
        chk("rr_seq4", obs_acks[4], 4'b0001);
        drain();

        // Backpressure with units 0 and 2.
        rst = 1'b0;
        cycle();
        rst       = 1'b1;
        out_ready = 1'b0;
        auto_rq   = 4'b0101;
        raise(0);
        raise(2);
        obs_acks.delete();
        for (int c = 0; c < 6; c++) begin
            out_ready = (c >= 4);
            cycle();
        end
        chk("bp_c0", obs_acks[0], 4'b0001);
        chk("bp_c1", obs_acks[1], 4'b0100);
        chk("bp_c2", obs_acks[2], 4'b0000);
        chk("bp_c3", obs_acks[3], 4'b0000);
        chk("bp_c4", obs_acks[4], 4'b0000);
        chk("bp_c5", obs_acks[5], 4'b0001);
        drain();

        // Simultaneous push and pop at count 1.
        out_ready = 1'b0;
        raise(0);
        cycle();
        out_ready = 1'b1;
        raise(3);
        cycle();
        chk("pp_ack", last_ack, 4'b1000);
        out_ready = 1'b0;
        cycle();
        chk("pp_valid", last_valid, 1'b1);
        chk("pp_unit", last_unit, 2'd3);
        drain();

        // Ten back-to-back transactions from unit 2 with out_ready toggling.
        sent     = 0;
        obs_pops = 0;
        for (int c = 0; c < 80; c++) begin
            if (sent == 10 && q.size() == 0 && unit_done == '0) break;
            out_ready = (c % 2 == 0);
            if (!unit_done[2] && sent < 10) begin
                raise(2);
                sent++;
            end
            cycle();
        end
        chk("wrap_pops", obs_pops, 10);
        drain();

        // Reset while full.
        out_ready = 1'b0;
        raise(0);
        raise(1);
        cycle();
        cycle();
        raise(2);
        rst = 1'b0;
        cycle();
        chk("midrst_ack", last_ack, 4'b0000);
        chk("midrst_valid", last_valid, 1'b0);
        rst = 1'b1;
        for (int u = 0; u < NU; u++) raise(u);
        cycle();
        chk("midrst_first", last_ack, 4'b0001);
        drain();

        // Random traffic with occasional resets.
        for (int c = 0; c < 400; c++) begin
            out_ready = ($urandom_range(0, 2) != 0);
            rst       = ($urandom_range(0, 59) != 0);
            for (int u = 0; u < NU; u++) begin
                if ($urandom_range(0, 3) == 0) raise(u);
            end
            cycle();
        end
        rst = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fp_wb_arbiter.md
Name: fp_wb_arbiter

Overview:
- Merges the FP intermediate-writeback ports of all FP execution units into the single shared normalization/rounding post-processing pipeline. Units include misc/wb2fp, FMA, div/sqrt and others.
- Grants one unit per cycle using round-robin order and queues its payload in a 2-entry output buffer.
- Returns ack to the granted unit.
- ack depends only on buffer occupancy and requests, never combinationally on the downstream ready.

Parameters:
- NUM_UNITS, 4, number of requesting FP units; 2..8.
- DEPTH, 2, output buffer entries; must be a power of two, at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low.
- unit_done  in  NUM_UNITS  per-unit writeback request; held high until acked.
- unit_payload  in  NUM_UNITS x $bits(fp_wb_payload_t)  per-unit packed payload.
- unit_ack  out  NUM_UNITS  one-hot or zero; payload accepted this cycle.
- out_valid  out  1  buffer head valid.
- out_payload  out  $bits(fp_wb_payload_t)  buffer head payload.
- out_unit  out  $clog2(NUM_UNITS)  source unit index of the head entry.
- out_ready  in  1  post-processing accepts the head this cycle.

Behaviour:
- Reset (rst==0 at a clk edge):
  - count=0, rd_ptr=0, wr_ptr=0.
  - Priority pointer rr_ptr=0, so unit 0 has highest priority.
  - unit_ack=0 and out_valid=0 while count==0.
  - Buffer data is not reset. out_payload is don't-care when out_valid==0.
- Space:
  - space = (count != DEPTH), computed from registered count only.
  - A pop in the same cycle does NOT create space; this is the deliberate no-combinational-path rule.
- Grant:
  - The first i with unit_done[i]==1, searched circularly from rr_ptr, when space==1.
  - unit_ack[i] = grant[i], in the same cycle as unit_done. This is zero-latency ack when space exists.
  - No unit_done set, or space==0 → unit_ack all zero.
- Push on ack:
  - Buffer[wr_ptr] <= {payload[i], i}.
  - wr_ptr increments modulo DEPTH.
  - rr_ptr <= (i+1) mod NUM_UNITS.
  - rr_ptr is unchanged when there is no grant.
- Pop: when out_valid && out_ready, rd_ptr increments modulo DEPTH.
- Count:
  - Push and pop in the same cycle → count unchanged.
  - Push only → count+1.
  - Pop only → count-1.
  - Count never exceeds DEPTH and never underflows.
  - out_ready while out_valid==0 is ignored.
- Latency: a payload acked in cycle N is visible on out_payload in cycle N+1 at the earliest. Order is strictly FIFO.
- Fairness: a continuously requesting unit is granted within NUM_UNITS grants.
- Requester rules: a unit may change payload only after ack. unit_done dropping without ack is a protocol violation.
- Reset mid-operation: queued entries are discarded and pending requests are not acked that cycle. Units re-request after reset.
- Wrap-around: the pointers are $clog2(DEPTH) bits, and full/empty are distinguished by count, not by pointer equality.
- Assertions, simulation only:
  - $onehot0(unit_ack).
  - unit_ack implies unit_done.
  - No push when count==DEPTH.

Decomposition:
- fpu_types gains typedef fp_wb_payload_t (packed). It holds the same fields as the intermediate-writeback interface, excluding done and ack:
  - rd (fp_t), id (id_t), hidden, grs (grs_t), clz (fp_shift_amt_t).
  - right_shift, right_shift_amt, subnormal, ignore_max_expo, d2s.
  - expo_overflow, carry, safe, fflags, rm.
- A top-level wrapper (outside this block) packs each unit's intermediate-writeback interface into fp_wb_payload_t.
- One sub-module: fp_rr_priority_pick. Inputs are a request vector and rr_ptr; outputs are a one-hot grant and its encoded index. It is combinational.

Test Plan:
- Single request: after reset, unit_done=0b0010 with payload id=5 → unit_ack=0b0010 the same cycle. Next cycle out_valid=1, out_unit=1, out_payload.id=5, and rr_ptr=2.
- Round-robin: all 4 units hold done and out_ready=1 constantly → the ack sequence is units 0,1,2,3,0. No unit is granted twice before all four are granted.
- Backpressure: out_ready=0 with units 0 and 2 requesting:
  - Acks go to unit 0 (cycle 0) and unit 2 (cycle 1). From cycle 2 unit_ack=0 while full.
  - Raising out_ready in cycle 4 pops; unit_ack resumes in cycle 5, not cycle 4.
- Simultaneous push/pop: count=1, out_ready=1, unit 3 requesting → ack and pop in the same cycle, count stays 1, and ordering is preserved.
- Wrap-around: 10 back-to-back single-unit transactions with out_ready toggling 1,0,1,0 → all 10 ids emerge in order, none lost or duplicated, and the pointers wrap correctly.
- Reset mid-operation: with count=2, drive rst=0 for one cycle → out_valid=0 and unit_ack=0 in that cycle. After release, unit 0 is granted first.
